// File: rtl/priority_pkg.sv
// Shared types and helpers for the priority arbiter.
package priority_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  // Binary grant code for a one-hot vector: code = n-1-index, 0 when no bit is set.
  function automatic int unsigned onehot2code(input logic [31:0] oh, input int unsigned n);
    int unsigned code;
    code = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (oh[i]) begin
        code = n - 1 - i;
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/priority_arbiter_if.sv
// Request/grant bundle between the bus masters and the arbiter.
interface priority_arbiter_if #(
  parameter int unsigned N = 8
);
  localparam int unsigned W = $clog2(N);

  logic [N-1:0] req;
  logic         ack;
  logic [N-1:0] gnt;
  logic [W-1:0] gnt_code;
  logic         gnt_valid;
  logic         revoked;

  modport master (output req, ack, input gnt, gnt_code, gnt_valid, revoked);
  modport slave  (input req, ack, output gnt, gnt_code, gnt_valid, revoked);

endinterface

// File: rtl/prio_pick.sv
// Combinational priority pick: lowest set request at or above start, wrapping to 0.
module prio_pick #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] start,
  output logic [N-1:0]         winner,
  output logic                 any
);

  logic [N-1:0] upper;

  // Requests at or above the start pointer take precedence over the wrapped ones.
  always_comb begin
    upper = '0;
    for (int j = 0; j < int'(N); j++) begin
      upper[j] = req[j] && (j >= int'(start));
    end
  end

  // x & -x isolates the lowest set bit.
  assign winner = (|upper) ? (upper & -upper) : (req & -req);
  assign any    = |req;

endmodule

// File: rtl/priority_arbiter.sv
// Registered N-way arbiter: grant held until ack, abandonment or MAX_HOLD timeout.
// gnt_code = N-1-winner. Define ARB_ROUND_ROBIN_EN for rotating priority;
// default build is fixed priority (index 0 highest).
module priority_arbiter
  import priority_pkg::*;
#(
  parameter int unsigned N        = 8,
  parameter int unsigned MAX_HOLD = 16
) (
  input logic               clk,
  input logic               reset,
  priority_arbiter_if.slave bus
);

  localparam int unsigned W  = $clog2(N);
  localparam int unsigned HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HoldLast = HW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [HW-1:0] HoldSat  = HW'((MAX_HOLD == 0) ? 1 : MAX_HOLD);

  arb_state_t    state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [W-1:0]  code_q, code_d;
  logic          revoked_q, revoked_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [N-1:0]  pick_req, pick_gnt;
  logic          pick_any;
  logic [W-1:0]  pick_start;
  logic          holder_exit, timeout;

  // While granted, the current holder is excluded from the follow-on pick.
  assign pick_req = (state_q == GRANT) ? (bus.req & ~gnt_q) : bus.req;

`ifdef ARB_ROUND_ROBIN_EN
  logic [W-1:0] ptr_q, ptr_d, ptr_rel;

  // Winner index is N-1-code, so winner+1 mod N is N-code, with code 0 wrapping to 0.
  always_comb begin
    ptr_rel = (code_q == '0) ? '0 : W'(N - int'(code_q));
  end

  assign pick_start = (state_q == GRANT) ? ptr_rel : ptr_q;

  // Pointer advances past the winner on every release or revoke.
  always_comb begin
    ptr_d = (state_q == GRANT && holder_exit) ? ptr_rel : ptr_q;
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign pick_start = '0;
`endif

  prio_pick #(
    .N(N)
  ) u_pick (
    .req    (pick_req),
    .start  (pick_start),
    .winner (pick_gnt),
    .any    (pick_any)
  );

  // Next state, grant and hold counter.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    hold_d      = hold_q;
    revoked_d   = 1'b0;
    holder_exit = 1'b0;
    timeout     = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt_d  = '0;
        hold_d = '0;
        if (pick_any) begin
          state_d = GRANT;
          gnt_d   = pick_gnt;
        end
      end
      GRANT: begin
        // ack beats timeout; a dropped request counts as a release.
        timeout     = (MAX_HOLD != 0) && !bus.ack && (hold_q == HoldLast);
        holder_exit = bus.ack || !(|(bus.req & gnt_q)) || timeout;
        if (holder_exit) begin
          revoked_d = timeout;
          hold_d    = '0;
          if (pick_any) begin
            gnt_d = pick_gnt;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else if (hold_q != HoldSat) begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Binary code of the next grant; zero when nothing is granted.
  always_comb begin
    code_d = W'(onehot2code(32'(gnt_d), N));
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      code_q    <= '0;
      revoked_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      code_q    <= code_d;
      revoked_q <= revoked_d;
      hold_q    <= hold_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_code  = code_q;
  assign bus.gnt_valid = (state_q == GRANT);
  assign bus.revoked   = revoked_q;

endmodule

// File: tb/tb_priority_arbiter.sv
// Directed bench for priority_arbiter, N=8, MAX_HOLD=4.
module tb_priority_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
  int   idx;

  priority_arbiter_if #(.N(8)) bus ();

  priority_arbiter #(
    .N        (8),
    .MAX_HOLD (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [7:0] g, input logic [2:0] c,
                            input logic v, input logic r);
    check({tag, ".gnt"}, 32'(bus.gnt), 32'(g));
    check({tag, ".code"}, 32'(bus.gnt_code), 32'(c));
    check({tag, ".valid"}, 32'(bus.gnt_valid), 32'(v));
    check({tag, ".revoked"}, 32'(bus.revoked), 32'(r));
  endtask

  initial begin
    reset   = 1'b1;
    bus.req = '0;
    bus.ack = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    expect_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);

    // First grant: index 0 beats index 7.
    bus.req = 8'b1000_0001;
    tick();
    expect_out("first", 8'h01, 3'b111, 1'b1, 1'b0);

    // Ack hands over directly to index 7.
    bus.ack = 1'b1;
    bus.req = 8'b1000_0000;
    tick();
    expect_out("handover", 8'h80, 3'b000, 1'b1, 1'b0);
    tick();
    expect_out("release_idle", 8'h00, 3'd0, 1'b0, 1'b0);
    bus.ack = 1'b0;
    bus.req = '0;
    tick();

    // Unacknowledged hold: four grant cycles, one revoke pulse, then re-grant.
    bus.req = 8'h04;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_out("hold", 8'h04, 3'd5, 1'b1, 1'b0);
    end
    tick();
    expect_out("revoke", 8'h00, 3'd0, 1'b0, 1'b1);
    tick();
    expect_out("regrant", 8'h04, 3'd5, 1'b1, 1'b0);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    bus.req = '0;
    expect_out("regrant_rel", 8'h00, 3'd0, 1'b0, 1'b0);
    tick();

    // Ack on the timeout cycle wins: no revoke pulse.
    bus.req = 8'h04;
    for (int i = 0; i < 4; i++) tick();
    bus.ack = 1'b1;
    tick();
    expect_out("ack_vs_timeout", 8'h00, 3'd0, 1'b0, 1'b0);
    bus.req = '0;

    // Ack in idle is ignored.
    tick();
    expect_out("ack_idle", 8'h00, 3'd0, 1'b0, 1'b0);
    bus.ack = 1'b0;

    // Abandonment: holder drops its request, next requester granted directly.
    bus.req = 8'h02;
    tick();
    expect_out("abandon_pre", 8'h02, 3'd6, 1'b1, 1'b0);
    bus.req = 8'h01;
    tick();
    expect_out("abandon_next", 8'h01, 3'd7, 1'b1, 1'b0);
    bus.req = '0;
    tick();
    expect_out("abandon_idle", 8'h00, 3'd0, 1'b0, 1'b0);

    // No preemption, then reset mid-grant.
    bus.req = 8'h10;
    tick();
    expect_out("hold10", 8'h10, 3'd3, 1'b1, 1'b0);
    bus.req = 8'h11;
    tick();
    expect_out("no_preempt", 8'h10, 3'd3, 1'b1, 1'b0);
    reset   = 1'b1;
    bus.req = '0;
    tick();
    expect_out("reset_mid", 8'h00, 3'd0, 1'b0, 1'b0);
    reset = 1'b0;

    // All requesting, ack every cycle.
    bus.req = 8'hFF;
    bus.ack = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
`ifdef ARB_ROUND_ROBIN_EN
      idx = i % 8;
`else
      idx = i % 2;
`endif
      expect_out("sweep", 8'(1 << idx), 3'(7 - idx), 1'b1, 1'b0);
    end
    bus.req = '0;
    tick();
    expect_out("sweep_end", 8'h00, 3'd0, 1'b0, 1'b0);
    bus.ack = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
